// File: rtl/cnn_pkg.sv
// Shared constants and types for the result write-back path.
package cnn_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned AXI_WIDTH  = 32;
  localparam int unsigned STRB_WIDTH = AXI_WIDTH / 8;

  localparam logic [STRB_WIDTH-1:0] STRB_FULL = 4'b1111;
  localparam logic [STRB_WIDTH-1:0] STRB_HALF = 4'b0011;

  typedef struct packed {
    logic [AXI_WIDTH-1:0]  data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
  } pack_word_t;

  typedef enum logic {
    HALF_EMPTY,
    HALF_FULL
  } pack_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Head word is presented combinationally; outputs read as zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = count;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only observable through a valid count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_pack_buffer.sv
// Packs 16-bit PE results pairwise into 32-bit words and queues them for
// the AXI write-data channel. An odd trailing element of a block is
// zero-padded and marked with a half-word strobe.
module result_pack_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned AXI_WIDTH  = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       in_vld,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_last,
  output logic                       in_rdy,
  output logic                       out_vld,
  output logic [AXI_WIDTH-1:0]       out_data,
  output logic [AXI_WIDTH/8-1:0]     out_strb,
  output logic                       out_last,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  import cnn_pkg::*;

  pack_state_t           state;
  pack_state_t           state_nxt;
  logic [DATA_WIDTH-1:0] staging;
  logic                  ready_q;
  logic                  accept;
  logic                  push;
  pack_word_t            push_word;
  pack_word_t            head_word;
  logic                  fifo_empty;
  logic                  fifo_full;

  // Input readiness uses the current count only; a same-cycle pop is not
  // credited, so a full FIFO costs one extra stall cycle.
  assign in_rdy = ready_q && !fifo_full;
  assign accept = in_vld && in_rdy;

  // Holds in_rdy low through reset and releases it on the first edge after.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  // Packing state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= HALF_EMPTY;
    else       state <= state_nxt;
  end

  // Next-state: a lone in_last element closes the block without leaving HALF_EMPTY.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        HALF_EMPTY: state_nxt = in_last ? HALF_EMPTY : HALF_FULL;
        HALF_FULL:  state_nxt = HALF_EMPTY;
        default:    state_nxt = HALF_EMPTY;
      endcase
    end
  end

  // Word formation and push in the cycle the completing element is accepted.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    if (accept) begin
      case (state)
        HALF_EMPTY: begin
          if (in_last) begin
            push           = 1'b1;
            push_word.data = {{DATA_WIDTH{1'b0}}, in_data};
            push_word.strb = STRB_HALF;
            push_word.last = 1'b1;
          end
        end
        HALF_FULL: begin
          push           = 1'b1;
          push_word.data = {in_data, staging};
          push_word.strb = STRB_FULL;
          push_word.last = in_last;
        end
        default: push = 1'b0;
      endcase
    end
  end

  // Low half-word staging; retained while the FIFO is full or input is idle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      staging <= '0;
    end else if (accept && state == HALF_EMPTY) begin
      staging <= in_data;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(pack_word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .wdata (push_word),
    .pop   (out_vld && out_rdy),
    .rdata (head_word),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign out_vld  = !fifo_empty;
  assign out_data = head_word.data;
  assign out_strb = head_word.strb;
  assign out_last = head_word.last;

endmodule

// File: tb/tb_result_pack_buffer.sv
// Directed bench for result_pack_buffer with a queue-based reference model.
module tb_result_pack_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_vld;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_rdy;
  logic        out_vld;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic        out_last;
  logic        out_rdy;
  logic [3:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected FIFO contents {data,strb,last}, pending elements, popped log.
  logic [36:0] exp_q[$];
  logic [15:0] pend[$];
  logic [36:0] got[$];
  bit          up;
  bit          toggle_en = 1'b0;

  result_pack_buffer #(
    .DATA_WIDTH (16),
    .AXI_WIDTH  (32),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_vld     (in_vld),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_rdy     (in_rdy),
    .out_vld    (out_vld),
    .out_data   (out_data),
    .out_strb   (out_strb),
    .out_last   (out_last),
    .out_rdy    (out_rdy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each handshake, from the packing rules alone.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      exp_q.delete();
      pend.delete();
      up = 1'b0;
    end else begin
      if (out_vld && out_rdy && exp_q.size() > 0) begin
        got.push_back({out_data, out_strb, out_last});
        void'(exp_q.pop_front());
      end
      if (in_vld && in_rdy) begin
        pend.push_back(in_data);
        if (pend.size() == 2) begin
          exp_q.push_back({pend[1], pend[0], 4'hF, in_last});
          pend.delete();
        end else if (in_last) begin
          exp_q.push_back({16'h0000, pend[0], 4'h3, 1'b1});
          pend.delete();
        end
      end
      up = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("out_vld", out_vld, exp_q.size() != 0);
    chk("fifo_level", fifo_level, exp_q.size());
    chk("in_rdy", in_rdy, up && exp_q.size() < DEPTH);
    if (exp_q.size() != 0) chk("head", {out_data, out_strb, out_last}, exp_q[0]);
    else                   chk("empty_out", {out_data, out_strb, out_last}, 37'h0);
  end

  always @(negedge clk) begin
    if (toggle_en) out_rdy = ~out_rdy;
  end

  task automatic send(input logic [15:0] d, input logic l);
    bit ok = 1'b0;
    @(negedge clk);
    in_vld = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      if (in_rdy) ok = 1'b1;
    end
    #1 in_vld = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_empty();
    int n = 0;
    @(negedge clk);
    while (out_vld && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", out_vld, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [36:0] w;
    bit ok;
    nrst = 1'b0; in_vld = 1'b0; in_data = '0; in_last = 1'b0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_rdy", in_rdy, 1'b0);
    chk("rst_level", fifo_level, 4'd0);
    #2 nrst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_in_rdy", in_rdy, 1'b1);

    // 1: even block with timing of first word
    out_rdy = 1'b1;
    got.delete();
    send(16'h0001, 1'b0);
    @(negedge clk);
    chk("t1_no_vld_after_e1", out_vld, 1'b0);
    send(16'h0002, 1'b0);
    @(negedge clk);
    chk("t1_vld_after_e2", out_vld, 1'b1);
    send(16'h0003, 1'b0);
    send(16'h0004, 1'b1);
    wait_empty();
    chk("t1_w0", got[0], {32'h00020001, 4'hF, 1'b0});
    chk("t1_w1", got[1], {32'h00040003, 4'hF, 1'b1});

    // 2: odd block, padded tail
    got.delete();
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    send(16'h0033, 1'b1);
    wait_empty();
    chk("t2_w0", got[0], {32'h00220011, 4'hF, 1'b0});
    chk("t2_w1", got[1], {32'h00000033, 4'h3, 1'b1});

    // 4: single-element block, then a pair proves state is back at HALF_EMPTY
    got.delete();
    send(16'h00AA, 1'b1);
    send(16'h00BB, 1'b0);
    send(16'h00CC, 1'b1);
    wait_empty();
    chk("t4_w0", got[0], {32'h000000AA, 4'h3, 1'b1});
    chk("t4_w1", got[1], {32'h00CC00BB, 4'hF, 1'b1});

    // 3: backpressure to full, 17th element held on input
    got.delete();
    @(negedge clk);
    out_rdy = 1'b0;
    for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i), i == 15);
    @(negedge clk);
    in_vld = 1'b1; in_data = 16'h0200; in_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_level_full", fifo_level, 4'd8);
    chk("t3_in_rdy_low", in_rdy, 1'b0);
    out_rdy = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      if (in_rdy) ok = 1'b1;
    end
    #1 in_vld = 1'b0;
    chk("t3_held_accepted", ok, 1'b1);
    wait_empty();
    chk("t3_count", got.size(), 9);
    for (int k = 0; k < 8; k++) begin
      w = {16'h0101 + 16'(2*k), 16'h0100 + 16'(2*k), 4'hF, k == 7};
      chk("t3_word", got[k], w);
    end
    chk("t3_held_word", got[8], {32'h00000200, 4'h3, 1'b1});

    // 5: 40 elements with out_rdy toggling; crosses pointer wrap
    got.delete();
    toggle_en = 1'b1;
    for (int i = 0; i < 40; i++) send(16'h0500 + 16'(i), i == 39);
    @(negedge clk);
    toggle_en = 1'b0;
    out_rdy = 1'b1;
    wait_empty();
    chk("t5_count", got.size(), 20);
    for (int k = 0; k < 20; k++) begin
      w = {16'h0501 + 16'(2*k), 16'h0500 + 16'(2*k), 4'hF, k == 19};
      chk("t5_word", got[k], w);
    end

    // 6: reset with queued words and a staged half-word
    @(negedge clk);
    out_rdy = 1'b0;
    for (int i = 0; i < 7; i++) send(16'h0600 + 16'(i), 1'b0);
    @(negedge clk);
    chk("t6_level_pre", fifo_level, 4'd3);
    #2 nrst = 1'b0;
    #1;
    chk("t6_rst_outs", {out_vld, out_data, out_strb, out_last, fifo_level, in_rdy}, '0);
    @(negedge clk);
    #2 nrst = 1'b1;
    got.delete();
    out_rdy = 1'b1;
    send(16'h0005, 1'b0);
    send(16'h0006, 1'b1);
    wait_empty();
    chk("t6_count", got.size(), 1);
    chk("t6_w0", got[0], {32'h00060005, 4'hF, 1'b1});

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
